// File: rtl/sdp_dc_ram_pkg.sv
// Shared types and sizes for the simple dual-port RAM and its FIFO controller.
package sdp_dc_ram_pkg;

  localparam int unsigned W_DATA  = 8;
  localparam int unsigned W_ADDR  = 4;
  localparam int unsigned W_DEPTH = 2 ** W_ADDR;

  typedef logic [W_DATA-1:0] data_t;
  typedef logic [W_ADDR-1:0] addr_t;
  typedef logic [W_ADDR:0]   ptr_t;
  typedef logic [W_ADDR:0]   cnt_t;

  // Pointer increment wraps naturally at 2**(W_ADDR+1); the MSB acts as the lap bit.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return p + ptr_t'(1);
  endfunction

endpackage

// File: rtl/sdp_dc_ram_if.sv
// Memory port bundle for sdp_dc_ram: write side on port A, read side on port B.
interface sdp_dc_ram_if;
  import sdp_dc_ram_pkg::*;

  logic  we;
  addr_t wr_addr_a;
  data_t data_a;
  logic  re;
  addr_t rd_addr_b;
  data_t rd_data_a;

  modport ram (
    input  we, wr_addr_a, data_a, re, rd_addr_b,
    output rd_data_a
  );

  modport ctrl (
    output we, wr_addr_a, data_a, re, rd_addr_b,
    input  rd_data_a
  );

endinterface

// File: rtl/fifo_ptr.sv
// W_ADDR+1-bit FIFO pointer register with increment enable and async active-low reset.
module fifo_ptr
  import sdp_dc_ram_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic inc,
  output ptr_t ptr
);

  ptr_t ptr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else if (inc) begin
      ptr_q <= ptr_inc(ptr_q);
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/fifo_ctrl.sv
// Single-clock FIFO controller driving an sdp_dc_ram through the ctrl modport.
// Define FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module fifo_ctrl
  import sdp_dc_ram_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  data_t            data_in,
  output logic             full,
  input  logic             pop,
  output data_t            data_out,
  output logic             dout_valid,
  output logic             empty,
  output cnt_t             count,
  sdp_dc_ram_if.ctrl       mem_if
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic             overflow,
  output logic             underflow
`endif
);

  ptr_t wr_ptr;
  ptr_t rd_ptr;
  logic push_ok;
  logic pop_ok;
  cnt_t count_q;
  cnt_t count_d;
  logic dout_valid_q;

  fifo_ptr u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (push_ok),
    .ptr (wr_ptr)
  );

  fifo_ptr u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (pop_ok),
    .ptr (rd_ptr)
  );

  // Same address with differing lap bits means the writer is one full lap ahead.
  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[W_ADDR-1:0] == rd_ptr[W_ADDR-1:0]) && (wr_ptr[W_ADDR] != rd_ptr[W_ADDR]);
    push_ok = push && !full;
    pop_ok  = pop && !empty;
  end

  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + cnt_t'(1);
      2'b01:   count_d = count_q - cnt_t'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q      <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      dout_valid_q <= pop_ok;
    end
  end

  assign mem_if.we        = push_ok;
  assign mem_if.wr_addr_a = wr_ptr[W_ADDR-1:0];
  assign mem_if.data_a    = data_in;
  assign mem_if.re        = pop_ok;
  assign mem_if.rd_addr_b = rd_ptr[W_ADDR-1:0];

  // The RAM registers read data on the same edge that registers dout_valid.
  assign data_out   = mem_if.rd_data_a;
  assign dout_valid = dout_valid_q;
  assign count      = count_q;

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q;
  logic underflow_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push && full) overflow_q <= 1'b1;
      if (pop && empty) underflow_q <= 1'b1;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl with a behavioural 1-cycle-latency RAM and a queue reference.
module tb_fifo_ctrl;
  import sdp_dc_ram_pkg::*;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  logic  push = 1'b0;
  logic  pop = 1'b0;
  data_t data_in = '0;
  logic  full;
  logic  empty;
  logic  dout_valid;
  data_t data_out;
  cnt_t  count;
`ifdef FIFO_ERR_FLAGS_EN
  logic  overflow;
  logic  underflow;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  data_t exp_q[$];
  data_t got_q[$];
  int    m_cnt = 0;
  logic  m_vld = 1'b0;
  data_t m_dat = '0;

  sdp_dc_ram_if mem_if ();

  fifo_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .data_in    (data_in),
    .full       (full),
    .pop        (pop),
    .data_out   (data_out),
    .dout_valid (dout_valid),
    .empty      (empty),
    .count      (count),
    .mem_if     (mem_if)
`ifdef FIFO_ERR_FLAGS_EN
    ,
    .overflow   (overflow),
    .underflow  (underflow)
`endif
  );

  always #5 clk = ~clk;

  data_t ram [W_DEPTH];
  always_ff @(posedge clk) begin
    if (mem_if.we) ram[mem_if.wr_addr_a] <= mem_if.data_a;
    if (mem_if.re) mem_if.rd_data_a <= ram[mem_if.rd_addr_b];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock of stimulus; outputs are checked at the negedge against the queue reference.
  task automatic drive(input logic p, input logic q, input data_t d);
    logic p_acc;
    logic q_acc;
    push    = p;
    pop     = q;
    data_in = d;
    p_acc   = p && (m_cnt < int'(W_DEPTH));
    q_acc   = q && (m_cnt > 0);
    @(negedge clk);
    check_eq("we", 32'(mem_if.we), 32'(p_acc));
    check_eq("re", 32'(mem_if.re), 32'(q_acc));
    check_eq("count", 32'(count), m_cnt);
    check_eq("empty", 32'(empty), 32'(m_cnt == 0));
    check_eq("full", 32'(full), 32'(m_cnt == int'(W_DEPTH)));
    check_eq("dout_valid", 32'(dout_valid), 32'(m_vld));
    if (m_vld) check_eq("data_out", 32'(data_out), 32'(m_dat));
    if (dout_valid) got_q.push_back(data_out);
    @(posedge clk);
    #1;
    m_vld = q_acc;
    if (q_acc) m_dat = exp_q.pop_front();
    if (p_acc) exp_q.push_back(d);
    m_cnt = m_cnt + int'(p_acc) - int'(q_acc);
    push  = 1'b0;
    pop   = 1'b0;
  endtask

  initial begin
    data_t k;
    data_t t2_exp [3];

    // 1: reset then idle
    #1 rst = 1'b0;
    check_eq("rst_empty", 32'(empty), 32'd1);
    check_eq("rst_full", 32'(full), 32'd0);
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_dout_valid", 32'(dout_valid), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    repeat (5) drive(1'b0, 1'b0, '0);

    // 2: three pushes then three back-to-back pops
    got_q.delete();
    drive(1'b1, 1'b0, 8'h11);
    drive(1'b1, 1'b0, 8'h22);
    drive(1'b1, 1'b0, 8'h33);
    check_eq("t2_count", 32'(count), 32'd3);
    repeat (3) drive(1'b0, 1'b1, '0);
    drive(1'b0, 1'b0, '0);
    t2_exp[0] = 8'h11;
    t2_exp[1] = 8'h22;
    t2_exp[2] = 8'h33;
    check_eq("t2_n_out", got_q.size(), 32'd3);
    for (int i = 0; i < 3 && i < got_q.size(); i++) check_eq("t2_data", 32'(got_q[i]), 32'(t2_exp[i]));
    check_eq("t2_empty", 32'(empty), 32'd1);
    check_eq("t2_count_end", 32'(count), 32'd0);

    // 3: fill, overflow attempt, drain
    got_q.delete();
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, data_t'(i));
    check_eq("t3_full", 32'(full), 32'd1);
    check_eq("t3_count", 32'(count), 32'd16);
    drive(1'b1, 1'b0, 8'hAA);
    check_eq("t3_count_after", 32'(count), 32'd16);
`ifdef FIFO_ERR_FLAGS_EN
    check_eq("t3_overflow", 32'(overflow), 32'd1);
`endif
    repeat (16) drive(1'b0, 1'b1, '0);
    drive(1'b0, 1'b0, '0);
    check_eq("t3_n_out", got_q.size(), 32'd16);
    for (int i = 0; i < 16 && i < got_q.size(); i++) check_eq("t3_data", 32'(got_q[i]), i);

    // 4: pop on empty, then simultaneous push/pop on empty
    got_q.delete();
    drive(1'b0, 1'b1, '0);
    check_eq("t4_dv", 32'(dout_valid), 32'd0);
    check_eq("t4_count", 32'(count), 32'd0);
`ifdef FIFO_ERR_FLAGS_EN
    check_eq("t4_underflow", 32'(underflow), 32'd1);
`endif
    drive(1'b1, 1'b1, 8'h5A);
    check_eq("t4_count_pp", 32'(count), 32'd1);
    drive(1'b0, 1'b1, '0);
    drive(1'b0, 1'b0, '0);
    check_eq("t4_n_out", got_q.size(), 32'd1);
    if (got_q.size() > 0) check_eq("t4_data", 32'(got_q[0]), 32'h5A);

    // 5: steady state at count 8 across several wraps
    got_q.delete();
    k = '0;
    repeat (8) begin
      drive(1'b1, 1'b0, k);
      k++;
    end
    repeat (40) begin
      drive(1'b1, 1'b1, k);
      k++;
    end
    check_eq("t5_count", 32'(count), 32'd8);
    repeat (8) drive(1'b0, 1'b1, '0);
    drive(1'b0, 1'b0, '0);
    check_eq("t5_n_out", got_q.size(), 32'd48);
    for (int i = 0; i < 48 && i < got_q.size(); i++) check_eq("t5_data", 32'(got_q[i]), i);

    // 6: reset while a pop is in flight
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, data_t'(8'hC0 + i));
    pop = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("t6_empty", 32'(empty), 32'd1);
    check_eq("t6_full", 32'(full), 32'd0);
    check_eq("t6_count", 32'(count), 32'd0);
    check_eq("t6_dv", 32'(dout_valid), 32'd0);
    check_eq("t6_re", 32'(mem_if.re), 32'd0);
    check_eq("t6_we", 32'(mem_if.we), 32'd0);
    @(posedge clk);
    #1;
    check_eq("t6_dv_hold", 32'(dout_valid), 32'd0);
    pop = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    got_q.delete();
    m_cnt = 0;
    m_vld = 1'b0;
    @(posedge clk);
    #1;
`ifdef FIFO_ERR_FLAGS_EN
    check_eq("t6_overflow", 32'(overflow), 32'd0);
    check_eq("t6_underflow", 32'(underflow), 32'd0);
`endif
    drive(1'b0, 1'b0, '0);
    drive(1'b1, 1'b0, 8'h3C);
    drive(1'b0, 1'b1, '0);
    drive(1'b0, 1'b0, '0);
    check_eq("t6_n_out", got_q.size(), 32'd1);
    if (got_q.size() > 0) check_eq("t6_data", 32'(got_q[0]), 32'h3C);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
Single-clock synchronous FIFO controller, the write/read initiator for the sdp_dc_ram memory port.
- Accepts push/pop requests from producer and consumer logic.
- Maintains write/read pointers, full/empty flags and occupancy count.
- Drives the RAM's we/wr_addr/data and re/rd_addr.
- Presents read data with a valid strobe that accounts for the RAM's 1-cycle read latency.
- Top-level fifo instantiates fifo_ctrl plus sdp_dc_ram, with clk tied to both clk_a and clk_b.

Parameters:
W_DATA, 8, data word width in bits (default taken from sdp_dc_ram_pkg)
W_ADDR, 4, RAM address width in bits
W_DEPTH, 2**W_ADDR, FIFO depth in words; must equal the RAM depth

Ports:
clk  input  1  core clock
rst  input  1  asynchronous active-low reset
push  input  1  write request; data_in is sampled when accepted
data_in  input  W_DATA  write data
full  output  1  FIFO holds W_DEPTH words
pop  input  1  read request
data_out  output  W_DATA  read data; valid only while dout_valid=1
dout_valid  output  1  one-cycle strobe, asserted the cycle after an accepted pop
empty  output  1  FIFO holds 0 words
count  output  W_ADDR+1  occupancy, range 0..W_DEPTH
mem_if  interface  -  sdp_dc_ram_if, new modport ctrl (drives we, wr_addr_a, data_a, re, rd_addr_b; receives rd_data_a)

Behaviour:
- Reset (rst=0, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0.
  - empty=1, full=0, dout_valid=0.
  - mem_if.we=0, mem_if.re=0.
  - data_out is don't-care.
  - Reset asserted mid-operation discards all contents; any in-flight read does not produce dout_valid.
- Pointers:
  - wr_ptr and rd_ptr are W_ADDR+1 bits. Low W_ADDR bits address the RAM; the MSB is the wrap bit.
  - Both increment modulo 2**(W_ADDR+1).
- Flags (combinational from registered pointers):
  - empty = (wr_ptr == rd_ptr).
  - full = (addr bits equal) && (wrap bits differ).
- Acceptance:
  - push_ok = push && !full
  - pop_ok = pop && !empty
  - Acceptance uses current-cycle flags only. A push to a full FIFO is ignored, and a pop from an empty FIFO is ignored; neither changes state.
- Memory drive (combinational):
  - mem_if.we = push_ok, mem_if.wr_addr_a = wr_ptr[W_ADDR-1:0], mem_if.data_a = data_in.
  - mem_if.re = pop_ok, mem_if.rd_addr_b = rd_ptr[W_ADDR-1:0].
- Update on posedge clk:
  - push_ok: wr_ptr+1.
  - pop_ok: rd_ptr+1.
  - count: +1 on push_ok only, -1 on pop_ok only, unchanged when both or neither.
- Read latency:
  - dout_valid <= pop_ok (registered).
  - data_out = mem_if.rd_data_a, which the RAM registers on the same edge.
  - Result: data appears exactly 1 cycle after the accepted pop. Back-to-back pops give back-to-back dout_valid.
- Simultaneous push and pop:
  - Not empty and not full: both accepted, count unchanged.
  - Empty: only the push is accepted; the word is poppable from the next cycle (no fall-through).
  - Full: only the pop is accepted; the push is dropped.
- Wrap-around: after W_DEPTH pushes and pops, the addresses wrap to 0, the wrap bit toggles, and flags stay correct.
- Ordering is strictly first-in first-out.

Optional Feature:
- Macro FIFO_ERR_FLAGS_EN.
- When defined, the block adds two outputs:
  - overflow: sticky, set on the cycle after push && full.
  - underflow: sticky, set on the cycle after pop && empty.
  - Both are cleared only by reset (reset value 0).
- When undefined, neither port nor the associated logic exists; illegal requests are silently ignored as above.

Decomposition:
- sdp_dc_ram_pkg (shared) holds:
  - W_DATA, W_ADDR, W_DEPTH
  - data_t (logic [W_DATA-1:0]), addr_t (logic [W_ADDR-1:0])
  - new ptr_t (logic [W_ADDR:0]) and cnt_t (logic [W_ADDR:0])
- sdp_dc_ram_if gains the ctrl modport.
- One natural sub-module, fifo_ptr: a W_ADDR+1-bit pointer register with increment enable and async reset, instantiated twice (write and read pointers).
- Flag, count and latency logic stay in fifo_ctrl.

Test Plan:
1. Reset then idle 5 cycles -> empty=1, full=0, count=0, dout_valid=0, we=re=0 throughout.
2. Push 0x11,0x22,0x33, then pop 3 consecutive cycles -> dout_valid high 3 cycles starting 1 cycle after the first pop; data_out 0x11,0x22,0x33; empty=1 and count=0 at the end.
3. Push W_DEPTH=16 words 0x00..0x0F -> full=1, count=16. A 17th push of 0xAA is ignored (we=0). Popping 16 words returns 0x00..0x0F with no 0xAA. With FIFO_ERR_FLAGS_EN, overflow=1 after the 17th push.
4. Pop on empty -> re=0, dout_valid stays 0, pointers unchanged. With FIFO_ERR_FLAGS_EN, underflow=1. Simultaneous push 0x5A / pop on empty -> count=1; a pop the next cycle returns 0x5A.
5. Hold count at 8, then 40 cycles of simultaneous push (incrementing data) and pop -> count stays 8; pointers wrap twice; output sequence is contiguous with no loss or duplication.
6. Push 4 words, assert rst low mid-cycle while a pop is in flight -> outputs return to reset values immediately, no dout_valid after reset; a subsequent push/pop returns only the new data.
